// File: rtl/go_done_arbiter.sv
// Round-robin arbiter sharing one go/done worker among NUM_REQ
// four-phase requesters, with a per-phase watchdog.
module go_done_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int GRANT_W       = 2,
  parameter int TIMEOUT_WIDTH = 8,
  parameter int TIMEOUT_MAX   = 200
) (
  input  logic               clk_div,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] ack_o,
  output logic [GRANT_W-1:0] grant_id_o,
  output logic               busy_o,
  output logic               go_out_o,
  input  logic               done_in_i,
  output logic               timeout_err_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_ACK     = 2'd3;

  localparam int SW = GRANT_W + 1;
  localparam logic [TIMEOUT_WIDTH-1:0] WD_MAX =
    TIMEOUT_WIDTH'(TIMEOUT_MAX);

  logic [1:0]               state_q, state_d;
  logic [GRANT_W-1:0]       ptr_q, ptr_d;
  logic [GRANT_W-1:0]       grant_q, grant_d;
  logic                     ok_q, ok_d;
  logic                     terr_q, terr_d;
  logic [TIMEOUT_WIDTH-1:0] wdog_q, wdog_d;

  logic [GRANT_W-1:0] pick;
  logic               hit;
  logic [SW-1:0]      sum;
  logic [GRANT_W-1:0] idx;
  logic [GRANT_W-1:0] nxt_ptr;
  logic               wd_hit;

  // Scan ptr, ptr+1, ... with wrap; first pending requester wins.
  always_comb begin
    pick = ptr_q;
    hit  = 1'b0;
    sum  = '0;
    idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + SW'(i);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      idx = sum[GRANT_W-1:0];
      if (!hit && req_i[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
  end

  assign nxt_ptr = (grant_q == GRANT_W'(NUM_REQ - 1)) ?
                   '0 : grant_q + 1'b1;
  assign wd_hit  = (wdog_q == WD_MAX);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ok_d    = ok_q;
    terr_d  = terr_q;
    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          grant_d = pick;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (done_in_i) begin
          ok_d    = 1'b1;
          state_d = S_RELEASE;
        end else if (wd_hit) begin
          ok_d    = 1'b0;
          terr_d  = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!done_in_i) begin
          state_d = ok_q ? S_ACK : S_IDLE;
          ptr_d   = nxt_ptr;
        end else if (wd_hit) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
          ptr_d   = nxt_ptr;
        end
      end
      S_ACK: begin
        if (!req_i[grant_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wdog_d = wdog_q;
    if (state_d != state_q) begin
      wdog_d = '0;
    end else if ((state_q == S_ISSUE ||
                  state_q == S_RELEASE) && !wd_hit) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      ok_q    <= 1'b0;
      terr_q  <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ok_q    <= ok_d;
      terr_q  <= terr_d;
      wdog_q  <= wdog_d;
    end
  end

  // State-decoded so go and ack fall the moment rst asserts.
  assign go_out_o      = (state_q == S_ISSUE);
  assign busy_o        = (state_q != S_IDLE);
  assign ack_o         = (state_q == S_ACK) ?
                         (NUM_REQ'(1) << grant_q) : '0;
  assign grant_id_o    = grant_q;
  assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_go_done_arbiter.sv
// Bench for go_done_arbiter: directed scenarios plus randomized
// requesters checked against a round-robin reference model.
module tb_go_done_arbiter;

  logic       clk_div = 1'b0;
  logic       rst     = 1'b1;
  logic [3:0] req     = 4'b0;
  logic [3:0] ack;
  logic [1:0] grant_id;
  logic       busy;
  logic       go_out;
  logic       done_in = 1'b0;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  bit whang = 1'b0;
  bit wrand = 1'b0;
  int wdly  = 0;
  int wcnt  = 0;
  int mptr  = 0;

  go_done_arbiter #(
    .NUM_REQ(4), .GRANT_W(2),
    .TIMEOUT_WIDTH(8), .TIMEOUT_MAX(200)
  ) dut (
    .clk_div      (clk_div),
    .rst          (rst),
    .req_i        (req),
    .ack_o        (ack),
    .grant_id_o   (grant_id),
    .busy_o       (busy),
    .go_out_o     (go_out),
    .done_in_i    (done_in),
    .timeout_err_o(timeout_err)
  );

  always #5 clk_div = ~clk_div;

  // Worker: raises done wdly cycles after seeing go, drops it after go drops.
  always @(negedge clk_div) begin
    if (rst) begin
      done_in = 1'b0;
      wcnt    = 0;
    end else if (!go_out) begin
      done_in = 1'b0;
      wcnt    = 0;
      if (wrand) wdly = $urandom_range(0, 3);
    end else if (!whang) begin
      if (wcnt >= wdly) done_in = 1'b1;
      else wcnt++;
    end
  end

  function automatic int rr_pick(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic do_reset();
    req   = 4'b0;
    whang = 1'b0;
    wrand = 1'b0;
    wdly  = 0;
    @(negedge clk_div);
    rst = 1'b1;
    @(negedge clk_div);
    rst  = 1'b0;
    mptr = 0;
  endtask

  task automatic test_reset();
    @(negedge clk_div);
    rst = 1'b1;
    req = 4'b0;
    #1;
    total++;
    if ({ack, grant_id, busy, go_out, timeout_err} !== 9'b0) begin
      bad++;
      $display("FAIL reset_outs got=%b exp=0",
               {ack, grant_id, busy, go_out, timeout_err});
    end
    @(negedge clk_div);
    rst = 1'b0;
    repeat (3) @(negedge clk_div);
    total++;
    if (busy !== 1'b0 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL idle_no_req got busy=%b gid=%0d exp 0/0",
               busy, grant_id);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    @(negedge clk_div);
    total++;
    if (go_out !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL single_go got go=%b busy=%b gid=%0d exp 1/1/0",
               go_out, busy, grant_id);
    end
    @(negedge clk_div);
    total++;
    if (go_out !== 1'b0 || ack !== 4'b0) begin
      bad++;
      $display("FAIL single_rel got go=%b ack=%b exp 0/0000",
               go_out, ack);
    end
    @(negedge clk_div);
    total++;
    if (ack !== 4'b0001) begin
      bad++;
      $display("FAIL single_ack got=%b exp=0001", ack);
    end
    req = 4'b0;
    @(negedge clk_div);
    total++;
    if (ack !== 4'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle got ack=%b busy=%b exp 0/0", ack, busy);
    end
    req = 4'b0011;
    @(negedge clk_div);
    total++;
    if (grant_id !== 2'd1) begin
      bad++;
      $display("FAIL single_ptr got=%0d exp=1", grant_id);
    end
  endtask

  task automatic test_all_four();
    int exp;
    bit got;
    do_reset();
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      exp = rr_pick(4'b1111, mptr);
      got = 1'b0;
      for (int c = 0; c < 30 && !got; c++) begin
        @(negedge clk_div);
        total++;
        if ($countones(ack) > 1) begin
          bad++;
          $display("FAIL rr_onehot got=%b exp<=1 bit", ack);
        end
        if (ack != 4'b0) got = 1'b1;
      end
      total++;
      if (!got || ack !== (4'b1 << exp) || grant_id !== 2'(exp)) begin
        bad++;
        $display("FAIL rr_order%0d got ack=%b gid=%0d exp gid=%0d",
                 s, ack, grant_id, exp);
      end
      mptr = (exp + 1) % 4;
      req[exp] = 1'b0;
      @(negedge clk_div);
      req[exp] = 1'b1;
    end
  endtask

  task automatic test_sparse();
    int  exp;
    bit  got;
    bit  seen13;
    do_reset();
    seen13 = 1'b0;
    req = 4'b0001;
    for (int s = 0; s < 3; s++) begin
      exp = rr_pick(req, mptr);
      got = 1'b0;
      for (int c = 0; c < 30 && !got; c++) begin
        @(negedge clk_div);
        if (ack[1] || ack[3]) seen13 = 1'b1;
        if (ack != 4'b0) got = 1'b1;
      end
      total++;
      if (!got || grant_id !== 2'(exp) || ack !== (4'b1 << exp)) begin
        bad++;
        $display("FAIL sparse%0d got ack=%b gid=%0d exp gid=%0d",
                 s, ack, grant_id, exp);
      end
      mptr = (exp + 1) % 4;
      req[exp] = 1'b0;
      @(negedge clk_div);
      req = 4'b0101;
    end
    total++;
    if (seen13) begin
      bad++;
      $display("FAIL sparse_idle_reqs got acked=1 exp=0");
    end
  endtask

  task automatic test_timeout();
    int  gc;
    bit  got;
    do_reset();
    whang = 1'b1;
    req   = 4'b0001;
    gc    = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_div);
      if (go_out) gc++;
      else if (gc > 0) break;
    end
    total++;
    if (gc != 201) begin
      bad++;
      $display("FAIL wdog_len got=%0d exp=201", gc);
    end
    total++;
    if (timeout_err !== 1'b1 || ack !== 4'b0) begin
      bad++;
      $display("FAIL wdog_flag got terr=%b ack=%b exp 1/0000",
               timeout_err, ack);
    end
    req = 4'b0;
    @(negedge clk_div);
    total++;
    if (busy !== 1'b0 || ack !== 4'b0) begin
      bad++;
      $display("FAIL wdog_idle got busy=%b ack=%b exp 0/0000", busy, ack);
    end
    whang = 1'b0;
    req   = 4'b0011;
    @(negedge clk_div);
    total++;
    if (grant_id !== 2'd1 || go_out !== 1'b1) begin
      bad++;
      $display("FAIL wdog_ptr got gid=%0d go=%b exp 1/1", grant_id, go_out);
    end
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk_div);
      if (ack != 4'b0) got = 1'b1;
    end
    req = 4'b0;
    @(negedge clk_div);
    total++;
    if (!got || busy !== 1'b0 || timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL wdog_sticky got ack=%b busy=%b terr=%b exp 1/0/1",
               got, busy, timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    int exp;
    whang = 1'b1;
    req   = 4'b0100;
    @(negedge clk_div);
    total++;
    if (go_out !== 1'b1 || grant_id !== 2'd2) begin
      bad++;
      $display("FAIL rstmid_go got go=%b gid=%0d exp 1/2", go_out, grant_id);
    end
    @(negedge clk_div);
    rst = 1'b1;
    req = 4'b0;
    #1;
    total++;
    if (go_out !== 1'b0 || busy !== 1'b0 || ack !== 4'b0 ||
        timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async got go=%b busy=%b ack=%b terr=%b exp 0",
               go_out, busy, ack, timeout_err);
    end
    @(negedge clk_div);
    rst   = 1'b0;
    whang = 1'b0;
    mptr  = 0;
    req   = 4'b1001;
    exp   = rr_pick(req, mptr);
    @(negedge clk_div);
    total++;
    if (grant_id !== 2'(exp)) begin
      bad++;
      $display("FAIL rstmid_ptr got=%0d exp=%0d", grant_id, exp);
    end
  endtask

  task automatic test_drop();
    int ac;
    do_reset();
    wdly = 2;
    req  = 4'b0010;
    @(negedge clk_div);
    req = 4'b0;
    ac  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_div);
      if (ack != 4'b0) begin
        ac++;
        total++;
        if (ack !== 4'b0010) begin
          bad++;
          $display("FAIL drop_ackval got=%b exp=0010", ack);
        end
      end else if (ac > 0) begin
        break;
      end
    end
    total++;
    if (ac != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_ack1 got cycles=%0d busy=%b exp 1/0", ac, busy);
    end
  endtask

  task automatic test_random();
    logic [3:0] last_req;
    logic       pbusy;
    logic [3:0] pack;
    int         mgrant;
    int         exp;
    int         waitc[4];
    do_reset();
    wrand    = 1'b1;
    last_req = 4'b0;
    pbusy    = 1'b0;
    pack     = 4'b0;
    mgrant   = 0;
    for (int i = 0; i < 4; i++) waitc[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_div);
      total++;
      if ($countones(ack) > 1) begin
        bad++;
        $display("FAIL rnd_onehot got=%b exp<=1 bit", ack);
      end
      if (busy && !pbusy) begin
        exp = rr_pick(last_req, mptr);
        total++;
        if (exp < 0 || grant_id !== 2'(exp)) begin
          bad++;
          $display("FAIL rnd_grant got=%0d exp=%0d", grant_id, exp);
        end
        mgrant = (exp < 0) ? 0 : exp;
        for (int i = 0; i < 4; i++)
          if (last_req[i] && i != mgrant) waitc[i]++;
        total++;
        if (waitc[mgrant] > 3) begin
          bad++;
          $display("FAIL rnd_fair got waits=%0d exp<=3", waitc[mgrant]);
        end
        waitc[mgrant] = 0;
      end
      if (ack != 4'b0 && pack == 4'b0) begin
        total++;
        if (ack !== (4'b1 << mgrant)) begin
          bad++;
          $display("FAIL rnd_ack got=%b exp=%b", ack, 4'b1 << mgrant);
        end
        mptr = (mgrant + 1) % 4;
      end
      pbusy = busy;
      pack  = ack;
      for (int i = 0; i < 4; i++) begin
        if (req[i] && ack[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if (!req[i] && !ack[i] && $urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
        end
      end
      last_req = req;
    end
    wrand = 1'b0;
    wdly  = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_sparse();
    test_timeout();
    test_reset_mid();
    test_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
